gemm_result_drain: RTL and testbench
====================================

// Module: gemm_result_drain
// PURPOSE
//   Downstream drain for the GEMM systolic array. Captures the NUM*NUM per-PE accumulator
//   results, each of which arrives as its own one-cycle valid pulse (skewed in time).
//   Once a full tile is held, streams the results out in raster order (row-major) over a
//   single WL-bit valid/ready port to the writeback/DMA stage.
// PARAMETERS
//   WL   32  result word width; matches the array accumulator width
//   NUM  16  array dimension; tile is NUM x NUM results
//   IW   $clog2(NUM*NUM)  derived local: flat index width (min 1)
// PORTS
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous, active-low reset
//   ena          in   1           global enable shared with the array
//   resultvalid  in   NUM*NUM     per-PE result strobe; bit k = row*NUM+col
//   resultvalue  in   WL*NUM*NUM  per-PE result; word k at [k*WL +: WL]
//   out_valid    out  1           output beat valid
//   out_ready    in   1           downstream accepts beat
//   out_data     out  WL          result word
//   out_row      out  $clog2(NUM) row of current beat
//   out_col      out  $clog2(NUM) column of current beat
//   out_last     out  1           beat is element NUM*NUM-1 of the tile
//   busy         out  1           FSM is in DRAIN
//   overflow     out  1           sticky; a result was lost
// BEHAVIOUR
//   - Reset (rst=0, async): pend[] = 0; cap[] = 0; state = COLLECT; idx = 0; overflow = 0.
//     All outputs 0. Reset mid-drain aborts the tile; no beats follow.
//   - Capture, ena=1, per k: resultvalid[k] & !pend[k] -> cap[k] <= value, pend[k] <= 1.
//     resultvalid[k] & pend[k] -> value dropped, cap[k] kept, overflow <= 1 (sticky until reset).
//   - FSM COLLECT: when &pend is seen, go to DRAIN on the next edge and set idx = 0.
//     out_valid is 0 throughout COLLECT.
//   - FSM DRAIN: out_valid = ena; out_data = cap[idx]; out_row = idx/NUM; out_col = idx%NUM;
//     out_last = (idx == NUM*NUM-1).
//     Handshake = out_valid & out_ready. On handshake: pend[idx] <= 0 and idx <= idx+1.
//     On handshake with out_last: idx <= 0 and state <= COLLECT.
//   - First beat appears 1 cycle after the final pend bit sets.
//     Throughput is 1 beat/cycle with out_ready held high.
//   - Without a handshake, out_data, out_row, out_col and out_last stay stable.
//   - Captures stay live during DRAIN: already-drained entries (< idx) refill for the next
//     tile; pending entries (>= idx) overflow per the capture rule.
//   - Same-cycle handshake on idx=k and resultvalid[k]: the beat carries the old cap[k];
//     cap[k] takes the new value; pend[k] stays 1 (set wins over clear).
//   - ena=0 freezes cap, pend, idx, state and overflow, ignores resultvalid, and forces
//     out_valid to 0. No handshake can complete.
//   - Values pass through unmodified (two's-complement bits); no width change.
// CONFIGURATION
//   GEMM_DRAIN_RELU_EN defined: out_data = cap[idx][WL-1] ? 0 : cap[idx] (ReLU on signed word).
//     The combinational clamp adds no latency. cap[] still stores the raw value.
//   Undefined: out_data = cap[idx] unmodified.
// STRUCTURE
//   - Shared package gemm_pkg: WL/NUM defaults, drain state typedef {COLLECT, DRAIN},
//     index-width function.
//   - One sub-module gemm_capture_cell: holds one cap/pend pair plus the overflow detect.
//     Instantiated NUM*NUM times in a generate loop.
//   - Top level: FSM, idx counter, output mux, sticky overflow OR-reduce.
// TESTING (bench uses NUM=2, WL=32 unless noted)
//   1. Skewed pulses load values 1,2,3,4 into k=0..3 with out_ready=1
//      -> beats 1,2,3,4 on consecutive cycles; (row,col) = (0,0),(0,1),(1,0),(1,1);
//      out_last only on beat 4; busy drops the cycle after.
//   2. Full tile loaded, out_ready pattern 0,1,0,1,...
//      -> each beat held stable while ready=0; 4 beats total, no duplicate or skipped element.
//   3. resultvalid[0] pulses twice in COLLECT (5, then 9)
//      -> overflow=1 and stays set; beat 0 = 5.
//   4. During DRAIN, resultvalid[0]=7 in the same cycle beat 0 handshakes
//      -> beat 0 = old value; next tile emits 7 at (0,0); overflow stays 0.
//   5. rst pulsed low mid-DRAIN after 2 beats -> outputs 0 immediately; later full tile 10..13
//      -> beats 10..13 from idx 0. ena=0 for 3 cycles mid-drain -> out_valid=0, no index advance.
//   6. cap value 0xFFFF_FFF6 (-10) -> out_data 0 with GEMM_DRAIN_RELU_EN;
//      0xFFFF_FFF6 without it; positive 0x0000_0010 unchanged in both.

Source files
------------

// File: rtl/gemm_pkg.sv
// -----------------------------------------------------------------------------
// gemm_pkg
//   Shared definitions for the GEMM result drain.
//   - WL_DEF / NUM_DEF : default word width and array dimension
//   - drain_state_t    : drain FSM states
//   - idx_width()      : index width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package gemm_pkg;

  localparam int WL_DEF  = 32;
  localparam int NUM_DEF = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } drain_state_t;

  // A single-entry range still needs one bit to hold index 0.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gemm_result_drain_if.sv
// -----------------------------------------------------------------------------
// gemm_result_drain_if
//   Raster-order result stream from the drain to the writeback/DMA stage.
//   out_valid / out_ready : beat handshake
//   out_data              : result word (WL bits)
//   out_row / out_col     : tile coordinates of the current beat
//   out_last              : final element of the tile
//   Modports: master (drain side), slave (writeback side).
// -----------------------------------------------------------------------------
interface gemm_result_drain_if
  import gemm_pkg::*;
#(
  parameter int WL  = WL_DEF,
  parameter int NUM = NUM_DEF
);
  localparam int RW = idx_width(NUM);

  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/gemm_capture_cell.sv
// -----------------------------------------------------------------------------
// gemm_capture_cell
//   Holds one captured PE result plus its pending flag, and flags a sticky
//   overflow when a new result arrives while the previous one is still pending.
//   clk, rst  : clock, asynchronous active-low reset
//   i_ena     : global enable; low freezes every register here
//   i_valid   : result strobe from the PE
//   i_value   : result word from the PE
//   i_clr     : this entry is being handed off downstream this cycle
//   o_cap     : captured word
//   o_pend    : captured word not yet drained
//   o_ovf     : sticky lost-result flag
// -----------------------------------------------------------------------------
module gemm_capture_cell #(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ena,
  input  logic          i_valid,
  input  logic [WL-1:0] i_value,
  input  logic          i_clr,
  output logic [WL-1:0] o_cap,
  output logic          o_pend,
  output logic          o_ovf
);
  logic [WL-1:0] r_cap;
  logic          r_pend;
  logic          r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap  <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_ena) begin
      // An entry leaving this cycle counts as free: a result landing on the
      // same edge refills it (pend stays set) instead of overflowing.
      if (i_valid && (!r_pend || i_clr)) begin
        r_cap  <= i_value;
        r_pend <= 1'b1;
      end else if (i_valid) begin
        r_ovf  <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_cap  = r_cap;
  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
endmodule

// File: rtl/gemm_result_drain.sv
// -----------------------------------------------------------------------------
// gemm_result_drain
//   Collects the NUM*NUM skewed per-PE accumulator results of a GEMM tile and,
//   once all are held, streams them out in row-major order over one
//   valid/ready port.
//   clk, rst     : clock, asynchronous active-low reset
//   ena          : global enable shared with the array (low freezes the drain)
//   resultvalid  : per-PE strobe, bit k = row*NUM+col
//   resultvalue  : per-PE word k at [k*WL +: WL]
//   drain        : output stream (gemm_result_drain_if.master)
//   busy         : draining a tile
//   overflow     : sticky, some result was lost
//   Build option: GEMM_DRAIN_RELU_EN clamps negative output words to zero
//   (stored values stay raw).
// -----------------------------------------------------------------------------
module gemm_result_drain
  import gemm_pkg::*;
#(
  parameter int WL  = WL_DEF,
  parameter int NUM = NUM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NUM*NUM-1:0]  resultvalid,
  input  logic [WL*NUM*NUM-1:0] resultvalue,
  gemm_result_drain_if.master drain,
  output logic                busy,
  output logic                overflow
);
  localparam int NE = NUM * NUM;
  localparam int IW = idx_width(NE);
  localparam int RW = idx_width(NUM);
  localparam logic [IW-1:0] NUM_I  = IW'(NUM);
  localparam logic [IW-1:0] LAST_I = IW'(NE - 1);

  drain_state_t  r_state, w_state_next;
  logic [IW-1:0] r_idx, w_idx_next;

  logic [NE-1:0] w_pend;
  logic [NE-1:0] w_ovf;
  logic [WL-1:0] w_cap [NE];
  logic [WL-1:0] w_sel;
  logic [IW-1:0] w_row_full;
  logic [IW-1:0] w_col_full;
  logic          w_last;
  logic          w_hs;

  // ---- capture array ---------------------------------------------------------
  for (genvar gi = 0; gi < NE; gi++) begin : g_cell
    gemm_capture_cell #(.WL(WL)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_ena   (ena),
      .i_valid (resultvalid[gi]),
      .i_value (resultvalue[gi*WL +: WL]),
      .i_clr   (w_hs && (r_idx == IW'(gi))),
      .o_cap   (w_cap[gi]),
      .o_pend  (w_pend[gi]),
      .o_ovf   (w_ovf[gi])
    );
  end

  // ---- FSM -------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COLLECT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (ena) begin
      case (r_state)
        COLLECT: begin
          if (&w_pend) begin
            w_state_next = DRAIN;
            w_idx_next   = '0;
          end
        end
        DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              w_state_next = COLLECT;
              w_idx_next   = '0;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_next = COLLECT;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  // ---- output stream ---------------------------------------------------------
  assign w_sel      = w_cap[r_idx];
  assign w_row_full = r_idx / NUM_I;
  assign w_col_full = r_idx % NUM_I;
  assign w_last     = (r_idx == LAST_I);
  assign w_hs       = drain.out_valid && drain.out_ready;

  assign drain.out_valid = (r_state == DRAIN) && ena;
  assign drain.out_row   = w_row_full[RW-1:0];
  assign drain.out_col   = w_col_full[RW-1:0];
  assign drain.out_last  = w_last;
`ifdef GEMM_DRAIN_RELU_EN
  // Signed ReLU on the way out; the clamp is purely combinational.
  assign drain.out_data  = w_sel[WL-1] ? '0 : w_sel;
`else
  assign drain.out_data  = w_sel;
`endif

  assign busy     = (r_state == DRAIN);
  assign overflow = |w_ovf;
endmodule

// File: tb/tb_gemm_result_drain.sv
module tb_gemm_result_drain;
  logic         clk;
  logic         rst;
  logic         ena;
  logic [3:0]   resultvalid;
  logic [127:0] resultvalue;
  logic         busy;
  logic         overflow;
  int           n_checks;
  int           n_fail;

  gemm_result_drain_if #(.WL(32), .NUM(2)) u_if ();

  gemm_result_drain #(.WL(32), .NUM(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .resultvalid (resultvalid),
    .resultvalue (resultvalue),
    .drain       (u_if),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [31:0] v);
    resultvalid = '0;
    resultvalid[k] = 1'b1;
    resultvalue[k*32 +: 32] = v;
    tick();
    resultvalid = '0;
  endtask

  // Skewed arrival with a gap, then one edge so the FSM enters DRAIN.
  task automatic load_tile(input logic [31:0] v0, v1, v2, v3);
    pulse(0, v0);
    pulse(1, v1);
    tick();
    pulse(2, v2);
    pulse(3, v3);
    tick();
  endtask

  task automatic check_beat(input string tag, input logic [31:0] d, input int n);
    check_val({tag, "_valid"}, u_if.out_valid, 1);
    check_val({tag, "_data"},  u_if.out_data, d);
    check_val({tag, "_row"},   u_if.out_row, n / 2);
    check_val({tag, "_col"},   u_if.out_col, n % 2);
    check_val({tag, "_last"},  u_if.out_last, (n == 3) ? 1 : 0);
  endtask

  // Drains one tile; with alt set, out_ready follows 0,1,0,1 and held beats
  // are re-checked on every stalled cycle.
  task automatic drain_check(input string tag, input logic [31:0] e0, e1, e2, e3,
                             input bit alt, input int exp_cycles);
    logic [31:0] ev [4];
    int n;
    int cyc;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      u_if.out_ready = alt ? cyc[0] : 1'b1;
      @(negedge clk);
      check_beat(tag, ev[n], n);
      if (u_if.out_ready && u_if.out_valid) begin
        $display("%s beat %0d: data=0x%08h row=%0d col=%0d last=%0b", tag, n,
                 u_if.out_data, u_if.out_row, u_if.out_col, u_if.out_last);
        n++;
      end
      tick();
      cyc++;
    end
    u_if.out_ready = 1'b1;
    check_val({tag, "_beats"}, n, 4);
    check_val({tag, "_cycles"}, cyc, exp_cycles);
    check_val({tag, "_busy_after"}, busy, 0);
    check_val({tag, "_valid_after"}, u_if.out_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    ena = 1'b1;
    resultvalid = '0;
    resultvalue = '0;
    u_if.out_ready = 1'b1;
    #12;
    check_val("rst_valid", u_if.out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_data", u_if.out_data, 0);
    check_val("rst_last", u_if.out_last, 0);
    tick();
    rst = 1'b1;
    tick();

    // 1: skewed load, back-to-back drain
    pulse(0, 1);
    pulse(1, 2);
    tick();
    pulse(2, 3);
    pulse(3, 4);
    check_val("t1_not_yet_valid", u_if.out_valid, 0);
    tick();
    drain_check("t1", 1, 2, 3, 4, 1'b0, 4);

    // 2: ready toggling, each beat held while stalled
    load_tile(32'h11, 32'h12, 32'h13, 32'h14);
    drain_check("t2", 32'h11, 32'h12, 32'h13, 32'h14, 1'b1, 8);

    // 3: double strobe on k=0 while pending
    pulse(0, 5);
    pulse(0, 9);
    @(negedge clk);
    check_val("t3_ovf_set", overflow, 1);
    tick();
    pulse(1, 6);
    pulse(2, 7);
    pulse(3, 8);
    tick();
    drain_check("t3", 5, 6, 7, 8, 1'b0, 4);
    check_val("t3_ovf_sticky", overflow, 1);
    rst = 1'b0;
    #1;
    check_val("t3_ovf_cleared", overflow, 0);
    tick();
    rst = 1'b1;
    tick();

    // 4: refill of entry 0 on the same edge it hands off
    load_tile(20, 21, 22, 23);
    resultvalid = 4'b0001;
    resultvalue[31:0] = 7;
    @(negedge clk);
    check_beat("t4_b0", 20, 0);
    tick();
    resultvalid = '0;
    @(negedge clk);
    check_beat("t4_b1", 21, 1);
    tick();
    @(negedge clk);
    check_beat("t4_b2", 22, 2);
    tick();
    @(negedge clk);
    check_beat("t4_b3", 23, 3);
    tick();
    check_val("t4_busy_after", busy, 0);
    check_val("t4_ovf", overflow, 0);
    pulse(1, 31);
    pulse(2, 32);
    pulse(3, 33);
    tick();
    drain_check("t4_next", 7, 31, 32, 33, 1'b0, 4);

    // 5: reset mid-drain, then ena freeze mid-drain
    load_tile(40, 41, 42, 43);
    tick();
    tick();
    @(negedge clk);
    check_beat("t5_pre", 42, 2);
    rst = 1'b0;
    #1;
    check_val("t5_rst_valid", u_if.out_valid, 0);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_data", u_if.out_data, 0);
    check_val("t5_rst_row", u_if.out_row, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check_val("t5_no_beats", u_if.out_valid, 0);
    load_tile(10, 11, 12, 13);
    @(negedge clk);
    check_beat("t5_b0", 10, 0);
    tick();
    @(negedge clk);
    check_beat("t5_b1", 11, 1);
    tick();
    ena = 1'b0;
    resultvalid = 4'b0100;
    resultvalue[95:64] = 99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t5_frz_valid", u_if.out_valid, 0);
      check_val("t5_frz_busy", busy, 1);
      check_val("t5_frz_data", u_if.out_data, 12);
      tick();
      resultvalid = '0;
    end
    ena = 1'b1;
    @(negedge clk);
    check_beat("t5_b2", 12, 2);
    check_val("t5_frz_ovf", overflow, 0);
    tick();
    @(negedge clk);
    check_beat("t5_b3", 13, 3);
    tick();
    check_val("t5_busy_after", busy, 0);

    // 6: signed values through the optional clamp
    load_tile(32'hFFFF_FFF6, 32'h0000_0010, 32'h8000_0000, 32'h7FFF_FFFF);
`ifdef GEMM_DRAIN_RELU_EN
    drain_check("t6", 32'h0, 32'h10, 32'h0, 32'h7FFF_FFFF, 1'b0, 4);
`else
    drain_check("t6", 32'hFFFF_FFF6, 32'h10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
